// File: rtl/button_down_counter_pkg.sv
// Shared LED-effects definitions: debounce FSM encoding and default board constants.
package button_down_counter_pkg;

   localparam int DEF_N          = 8;
   localparam int DEF_DEB_CYCLES = 16;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } deb_state_t;

endpackage

// File: rtl/button_down_counter_if.sv
// Board-side signal bundle of the button down counter: raw button, preload, LED count and flags.
interface button_down_counter_if
   import button_down_counter_pkg::*;
#(
   parameter int N = DEF_N
);
   logic         btn;
   logic         load;
   logic [N-1:0] load_val;
   logic [N-1:0] q;
   logic         zero;
   logic         tc_pulse;

   modport master (
      output btn, load, load_val,
      input  q, zero, tc_pulse
   );

   modport slave (
      input  btn, load, load_val,
      output q, zero, tc_pulse
   );
endinterface

// File: rtl/button_down_counter_btn_debounce.sv
// Button front end: 2-flop synchronizer, debounce FSM and a registered one-cycle step per press.
module btn_debounce
   import button_down_counter_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic step
);
   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   // Entering a check state is the first stable sample, so the last one is seen at count DEB_CYCLES-2.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 2);

   logic [1:0]    sync_reg;
   logic          btn_s;
   deb_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          step_reg, step_next;

   assign btn_s = sync_reg[1];
   assign step  = step_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg  <= 2'b00;
         state_reg <= IDLE;
         cnt_reg   <= '0;
         step_reg  <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], btn};
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         step_reg  <= step_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      step_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (btn_s) begin
               state_next = PRESS_CHK;
               cnt_next   = '0;
            end
         end
         PRESS_CHK: begin
            if (!btn_s) begin
               state_next = IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = PRESSED;
               cnt_next   = cnt_reg + 1'b1;
               step_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_next = RELEASE_CHK;
               cnt_next   = '0;
            end
         end
         RELEASE_CHK: begin
            if (btn_s) begin
               state_next = PRESSED;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: rtl/button_down_counter.sv
// Button-stepped down counter: preload beats step; zero wraps or saturates; tc_pulse marks 1 -> 0.
module button_down_counter
   import button_down_counter_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter bit WRAP       = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   button_down_counter_if.slave  bus
);
   logic         step;
   logic [N-1:0] q_reg, q_next;
   logic         tc_reg, tc_next;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (bus.btn),
      .step  (step)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg  <= '1;
         tc_reg <= 1'b0;
      end else begin
         q_reg  <= q_next;
         tc_reg <= tc_next;
      end
   end

   always_comb begin
      q_next  = q_reg;
      tc_next = 1'b0;
      if (bus.load) begin
         q_next = bus.load_val;
      end else if (step) begin
         if (q_reg == N'(1)) begin
            q_next  = '0;
            tc_next = 1'b1;
         end else if (q_reg == '0) begin
            q_next = WRAP ? '1 : '0;
         end else begin
            q_next = q_reg - N'(1);
         end
      end
   end

   assign bus.q        = q_reg;
   assign bus.zero     = (q_reg == '0);
   assign bus.tc_pulse = tc_reg;
endmodule

// File: tb/tb_button_down_counter.sv
// Randomized scoreboard bench: one wrapping and one saturating counter share stimulus against a run-length reference.
module tb_button_down_counter;
   localparam int N   = 8;
   localparam int DEB = 4;

   typedef struct {
      logic [7:0] q_w;
      logic [7:0] q_s;
      logic       tc_w;
      logic       tc_s;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   button_down_counter_if #(.N(N)) if_w ();
   button_down_counter_if #(.N(N)) if_s ();

   button_down_counter #(.N(N), .DEB_CYCLES(DEB), .WRAP(1'b1)) u_dut_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (if_w.slave)
   );

   button_down_counter #(.N(N), .DEB_CYCLES(DEB), .WRAP(1'b0)) u_dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (if_s.slave)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // Reference: btn delayed two samples, then a press/release is accepted once the
   // sample stream has differed from the debounced level for DEB samples in a row.
   logic [7:0] m_q_w, m_q_s;
   logic       m_tc_w, m_tc_s;
   logic       m_d1, m_d2, m_level, m_step;
   int         m_run;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %h, expected %h", name, $time, got, expv);
      end
   endtask

   task automatic model_edge(input logic b, input logic ld, input logic [7:0] lv, input logic r);
      exp_t e;
      logic bs;
      if (!r) begin
         m_q_w = 8'hFF; m_q_s = 8'hFF; m_tc_w = 1'b0; m_tc_s = 1'b0;
         m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_step = 1'b0; m_run = 0;
      end else begin
         bs   = m_d2;
         m_d2 = m_d1;
         m_d1 = b;
         m_tc_w = 1'b0;
         m_tc_s = 1'b0;
         if (ld) begin
            m_q_w = lv;
            m_q_s = lv;
         end else if (m_step) begin
            m_tc_w = (m_q_w == 8'd1);
            m_tc_s = (m_q_s == 8'd1);
            m_q_w  = (m_q_w == 8'd0) ? 8'hFF : m_q_w - 8'd1;
            m_q_s  = (m_q_s == 8'd0) ? 8'h00 : m_q_s - 8'd1;
         end
         m_step = 1'b0;
         if (bs != m_level) begin
            m_run++;
            if (m_run == DEB) begin
               m_level = bs;
               m_run   = 0;
               m_step  = bs;
            end
         end else begin
            m_run = 0;
         end
      end
      e.q_w = m_q_w; e.q_s = m_q_s; e.tc_w = m_tc_w; e.tc_s = m_tc_s;
      exp_q.push_back(e);
   endtask

   // Drive one clock edge worth of inputs on the falling edge; reset acts at once.
   task automatic tick(input logic b, input logic ld, input logic [7:0] lv, input logic r);
      @(negedge clk);
      reset       = r;
      if_w.btn    = b;  if_s.btn    = b;
      if_w.load   = ld; if_s.load   = ld;
      if_w.load_val = lv; if_s.load_val = lv;
      model_edge(b, ld, lv, r);
      if (!r) begin
         #1;
         check("async_reset_q_wrap", if_w.q, 8'hFF);
         check("async_reset_q_sat", if_s.q, 8'hFF);
         check("async_reset_zero", {6'd0, if_w.zero, if_s.zero}, 8'd0);
         check("async_reset_tc", {6'd0, if_w.tc_pulse, if_s.tc_pulse}, 8'd0);
      end
   endtask

   task automatic hold(input logic b, input int cycles);
      for (int i = 0; i < cycles; i++) tick(b, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic press();
      hold(1'b1, DEB + 4);
      hold(1'b0, DEB + 4);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q_wrap", if_w.q, e.q_w);
            check("q_sat", if_s.q, e.q_s);
            check("zero_wrap", {7'd0, if_w.zero}, {7'd0, e.q_w == 8'd0});
            check("zero_sat", {7'd0, if_s.zero}, {7'd0, e.q_s == 8'd0});
            check("tc_wrap", {7'd0, if_w.tc_pulse}, {7'd0, e.tc_w});
            check("tc_sat", {7'd0, if_s.tc_pulse}, {7'd0, e.tc_s});
         end
      end
   end

   initial begin : stimulus
      int dur;
      logic b;
      logic ld;
      logic [7:0] lv;
      if_w.btn = 1'b0; if_s.btn = 1'b0;
      if_w.load = 1'b0; if_s.load = 1'b0;
      if_w.load_val = 8'h00; if_s.load_val = 8'h00;

      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
      hold(1'b0, 10);

      // Held press: one step only, no auto-repeat.
      hold(1'b1, 56);
      hold(1'b0, DEB + 6);

      // Bounce shorter than the debounce window.
      hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 10);

      // Preload 2, count down through the terminal count, then step at zero.
      tick(1'b0, 1'b1, 8'h02, 1'b1);
      press();
      press();
      press();

      // Load coincident with a step, then reset while the button is held.
      for (int i = 0; i < 16; i++) tick(1'b1, m_step, 8'h55, 1'b1);
      for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
      hold(1'b1, 12);
      hold(1'b0, 10);

      // Random bouncy presses with occasional preloads and resets.
      for (int seg = 0; seg < 400; seg++) begin
         b   = 1'(($urandom_range(0, 99) < 55));
         dur = $urandom_range(1, 2 * DEB + 2);
         for (int i = 0; i < dur; i++) begin
            ld = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
               0:       lv = 8'h00;
               1:       lv = 8'h01;
               2:       lv = 8'h02;
               default: lv = 8'($urandom);
            endcase
            tick(b, ld, lv, ($urandom_range(0, 199) != 0));
         end
      end
      hold(1'b0, 3);

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/button_down_counter.md
# button_down_counter

Button-stepped 8-bit down counter for the LED effect boards, the counting-down counterpart of the button-clocked up counter. A raw push-button is synchronized, debounced and edge-detected inside the system clock domain, so the button is never used as a clock. Each confirmed press decrements an LED-facing count. The block supports a synchronous preload, wrap or saturate at zero, and a one-cycle terminal-count pulse.

## Interface
- N, 8, counter width (LED count)
- DEB_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change (≥2)
- WRAP, 1, 1: wrap 0 → 2^N−1 on a step; 0: saturate at 0

- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately while low
- btn  input  1  raw mechanical button, asynchronous to clk, active-high, bouncy
- load  input  1  synchronous load strobe, sampled at clk edge
- load_val  input  N  value loaded into the count when load=1
- q  output  N  current count, drives LEDs directly
- zero  output  1  high when q == 0 (combinational from q)
- tc_pulse  output  1  one-cycle pulse on the step that takes q from 1 to 0

## Operation
- Reset (reset=0): q = 2^N−1 (all LEDs on), zero=0, tc_pulse=0, synchronizer flops=0, debounced level=0, debounce count=0, FSM=IDLE.
- Synchronizer: 2-flop chain on btn produces btn_s.
- Debouncer FSM:
  - States IDLE (debounced 0), PRESS_CHK, PRESSED (debounced 1), RELEASE_CHK.
  - IDLE→PRESS_CHK when btn_s=1; count cleared.
  - PRESS_CHK: count increments each cycle btn_s=1. Any btn_s=0 returns to IDLE.
  - PRESS_CHK→PRESSED when count reaches DEB_CYCLES−1 with btn_s=1. The transition emits a one-cycle internal step.
  - PRESSED→RELEASE_CHK when btn_s=0.
  - RELEASE_CHK→IDLE after DEB_CYCLES consecutive btn_s=0 samples. Any btn_s=1 returns to PRESSED. No step is emitted on release.
- Count update priority (highest first):
  - load=1: q ← load_val. A coincident step is discarded and tc_pulse=0.
  - step with q>1: q ← q−1.
  - step with q==1: q ← 0 and tc_pulse=1 for one cycle.
  - step with q==0: WRAP=1 → q ← 2^N−1 with tc_pulse=0; WRAP=0 → q holds 0 with tc_pulse=0.
  - Otherwise q holds.
- Arithmetic is modulo 2^N; no other width extension.
- Holding the button generates exactly one step; there is no auto-repeat.

## Timing
- btn stable high from edge k: btn_s=1 at edge k+2. The step is internal at edge k+1+DEB_CYCLES, and q/tc_pulse update at edge k+2+DEB_CYCLES.
- A bounce shorter than DEB_CYCLES samples produces no step.
- Minimum press-to-press spacing accepted: release must be stable for DEB_CYCLES samples.
- load takes effect at the same edge it is sampled (latency 1 to q).
- zero follows q with no extra cycle. tc_pulse is registered and is high exactly in the cycle where q first reads 0.
- reset asserted mid-press: all state clears asynchronously. After release of reset with btn still held, a fresh full debounce is needed before a step.
- reset deassertion is assumed synchronous to clk at board level. No reset synchronizer is inside the block.

## Structure
- The shared LED-effects package holds:
  - the debounce FSM state encoding (2-bit enum IDLE/PRESS_CHK/PRESSED/RELEASE_CHK);
  - the default constants N=8 and DEB_CYCLES=16.
- One natural sub-module is btn_debounce (synchronizer + FSM + step pulse). It has ports clk, reset, btn, step, and is reusable by the up-counter board variant.
- The top contains only the load/step priority logic, the count register, zero and tc_pulse.

## Test plan
Simulate with DEB_CYCLES=4, N=8.
- Reset, then idle 10 cycles → q=8'hFF, zero=0, tc_pulse=0 throughout.
- btn high stable from edge 0 → q becomes 8'hFE exactly at edge 6 and stays 8'hFE while btn is held for 50 more cycles (no repeat).
- btn glitches high for 3 cycles, low 2, high 2, then stays low → q unchanged at 8'hFF, FSM returns to IDLE.
- load=1 with load_val=8'h02, then two clean presses → q=01, then 00. zero rises with q=00, and tc_pulse is high for exactly that one cycle.
- Another clean press at q=00: WRAP=1 → q=8'hFF with tc_pulse=0; rerun with WRAP=0 → q stays 00 with tc_pulse=0.
- load=1 (load_val=8'h55) on the same edge as a step, then reset pulled low during a held press → q=8'h55 after the load, q=8'hFF immediately on reset, and no step occurs after reset until a full 4-sample debounce completes.
